mem_access_arbiter: RTL and testbench

//  Shares the single-port data RAM register block between two requesters:

---
 rtl/mem_access_arbiter_if.sv | 46 ++++
 rtl/mem_access_arbiter.sv | 108 ++++++++++
 tb/tb_mem_access_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_arbiter_if.sv
// Signal bundle between the data-RAM arbiter, its two requesters (pipeline P and
// debug D) and the RAM register block. The arbiter uses the slave view.
interface mem_access_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              P_REQ;
  logic              P_READ_WRN;
  logic [ADDR_W-1:0] P_ADDR;
  logic [DATA_W-1:0] P_WDATA;
  logic              P_GNT;
  logic              P_STALL;
  logic              P_RVALID;
  logic [DATA_W-1:0] P_RDATA;

  logic              D_REQ;
  logic              D_READ_WRN;
  logic [ADDR_W-1:0] D_ADDR;
  logic [DATA_W-1:0] D_WDATA;
  logic              D_GNT;
  logic              D_RVALID;
  logic [DATA_W-1:0] D_RDATA;

  logic              MEM_ACCESS_READ_WRN;
  logic [ADDR_W-1:0] MEM_ACCESS_ADDRESS_BUS;
  logic [DATA_W-1:0] MEM_ACCESS_DATA_OUT_BUS;
  logic [DATA_W-1:0] MEM_ACCESS_DATA_IN_BUS;

  modport slave (
    input  P_REQ, P_READ_WRN, P_ADDR, P_WDATA,
    output P_GNT, P_STALL, P_RVALID, P_RDATA,
    input  D_REQ, D_READ_WRN, D_ADDR, D_WDATA,
    output D_GNT, D_RVALID, D_RDATA,
    output MEM_ACCESS_READ_WRN, MEM_ACCESS_ADDRESS_BUS, MEM_ACCESS_DATA_OUT_BUS,
    input  MEM_ACCESS_DATA_IN_BUS
  );

  modport master (
    output P_REQ, P_READ_WRN, P_ADDR, P_WDATA,
    input  P_GNT, P_STALL, P_RVALID, P_RDATA,
    output D_REQ, D_READ_WRN, D_ADDR, D_WDATA,
    input  D_GNT, D_RVALID, D_RDATA,
    input  MEM_ACCESS_READ_WRN, MEM_ACCESS_ADDRESS_BUS, MEM_ACCESS_DATA_OUT_BUS,
    output MEM_ACCESS_DATA_IN_BUS
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Two-port arbiter for the single-port data RAM: fixed priority to the pipeline,
// with a starvation guard that hands the debug port one forced grant.
module mem_access_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 CK_REF,
  input logic                 RST_N,
  mem_access_arbiter_if.slave bus
);

  typedef enum logic { PRI_P, PRI_D } pri_e;
  typedef enum logic { PORT_P, PORT_D } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } tag_t;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_TRIP = cnt_t'(STARVE_LIMIT - 1);
  localparam cnt_t CNT_MAX  = cnt_t'(STARVE_LIMIT);

  pri_e              state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic              p_gnt, d_gnt, d_denied;
  tag_t              tag_in, tag1_q, tag2_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    p_gnt   = 1'b0;
    d_gnt   = 1'b0;
    state_d = state_q;
    cnt_d   = '0;

    // Grants are held low while reset is asserted, regardless of requests.
    if (RST_N) begin
      if (state_q == PRI_P) begin
        if (bus.P_REQ)      p_gnt = 1'b1;
        else if (bus.D_REQ) d_gnt = 1'b1;
      end else begin
        if (bus.D_REQ)      d_gnt = 1'b1;
        else if (bus.P_REQ) p_gnt = 1'b1;
      end
    end

    d_denied = bus.D_REQ & ~d_gnt;
    if (d_denied) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + cnt_t'(1);

    // Reaching the trip count while still denied gives D the next cycle.
    if (state_q == PRI_P) begin
      if (d_denied && cnt_q >= CNT_TRIP) state_d = PRI_D;
    end else begin
      if (d_gnt || !bus.D_REQ) state_d = PRI_P;
    end

    tag_in.valid = (p_gnt & bus.P_READ_WRN) | (d_gnt & bus.D_READ_WRN);
    tag_in.port  = d_gnt ? PORT_D : PORT_P;
  end

  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= PRI_P;
      cnt_q   <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag1_q  <= tag_in;
      tag2_q  <= tag1_q;
      if (p_gnt) begin
        rw_q   <= bus.P_READ_WRN;
        addr_q <= bus.P_ADDR;
        if (!bus.P_READ_WRN) dout_q <= bus.P_WDATA;
      end else if (d_gnt) begin
        rw_q   <= bus.D_READ_WRN;
        addr_q <= bus.D_ADDR;
        if (!bus.D_READ_WRN) dout_q <= bus.D_WDATA;
      end else begin
        // Idle cycles park the bus in read mode; address and data hold.
        rw_q <= 1'b1;
      end
    end
  end

  assign bus.P_GNT    = p_gnt;
  assign bus.D_GNT    = d_gnt;
  assign bus.P_STALL  = bus.P_REQ & ~p_gnt;
  assign bus.P_RVALID = tag2_q.valid && (tag2_q.port == PORT_P);
  assign bus.D_RVALID = tag2_q.valid && (tag2_q.port == PORT_D);
  assign bus.P_RDATA  = bus.MEM_ACCESS_DATA_IN_BUS;
  assign bus.D_RDATA  = bus.MEM_ACCESS_DATA_IN_BUS;

  assign bus.MEM_ACCESS_READ_WRN     = rw_q;
  assign bus.MEM_ACCESS_ADDRESS_BUS  = addr_q;
  assign bus.MEM_ACCESS_DATA_OUT_BUS = dout_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed scenarios plus a random
// run checked against a cycle-indexed model of the grant and return rules.
module tb_mem_access_arbiter;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic CK_REF = 1'b0;
  logic RST_N  = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CK_REF = ~CK_REF;

  mem_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .CK_REF(CK_REF),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // NOTE: inputs change with blocking assignments 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge CK_REF);
    #1;
  endtask

  task automatic set_p(input bit req, input bit rw, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    bus.P_REQ = req; bus.P_READ_WRN = rw; bus.P_ADDR = a; bus.P_WDATA = d;
  endtask

  task automatic set_d(input bit req, input bit rw, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    bus.D_REQ = req; bus.D_READ_WRN = rw; bus.D_ADDR = a; bus.D_WDATA = d;
  endtask

  task automatic idle_inputs();
    set_p(1'b0, 1'b1, '0, '0);
    set_d(1'b0, 1'b1, '0, '0);
    bus.MEM_ACCESS_DATA_IN_BUS = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    RST_N = 1'b0;
    repeat (2) @(posedge CK_REF);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST_N = 1'b0;
    set_p(1'b1, 1'b0, 16'h1234, 32'h5555_5555);
    set_d(1'b1, 1'b1, 16'h4321, 32'h6666_6666);
    @(negedge CK_REF);
    n_checks++;
    if ({bus.P_GNT, bus.D_GNT, bus.P_RVALID, bus.D_RVALID} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_gnt_rvalid: got %b expected 0000",
               {bus.P_GNT, bus.D_GNT, bus.P_RVALID, bus.D_RVALID});
    end
    n_checks++;
    if ({bus.MEM_ACCESS_READ_WRN, bus.MEM_ACCESS_ADDRESS_BUS, bus.MEM_ACCESS_DATA_OUT_BUS}
        !== {1'b1, 16'h0000, 32'h0000_0000}) begin
      n_fail++;
      $display("FAIL reset_bus: got rw=%b addr=%h dout=%h expected rw=1 addr=0000 dout=00000000",
               bus.MEM_ACCESS_READ_WRN, bus.MEM_ACCESS_ADDRESS_BUS, bus.MEM_ACCESS_DATA_OUT_BUS);
    end
    apply_reset();
  endtask

  task automatic test_p_read();
    apply_reset();
    set_p(1'b1, 1'b1, 16'h0010, '0);
    @(negedge CK_REF);
    n_checks++;
    if ({bus.P_GNT, bus.D_GNT, bus.P_STALL} !== 3'b100) begin
      n_fail++;
      $display("FAIL p_read_gnt: got %b expected 100", {bus.P_GNT, bus.D_GNT, bus.P_STALL});
    end
    next_cycle();
    set_p(1'b0, 1'b1, '0, '0);
    @(negedge CK_REF);
    n_checks++;
    if ({bus.MEM_ACCESS_READ_WRN, bus.MEM_ACCESS_ADDRESS_BUS, bus.P_RVALID, bus.D_RVALID}
        !== {1'b1, 16'h0010, 2'b00}) begin
      n_fail++;
      $display("FAIL p_read_issue: got rw=%b addr=%h rv=%b%b expected rw=1 addr=0010 rv=00",
               bus.MEM_ACCESS_READ_WRN, bus.MEM_ACCESS_ADDRESS_BUS, bus.P_RVALID, bus.D_RVALID);
    end
    next_cycle();
    bus.MEM_ACCESS_DATA_IN_BUS = 32'h0000_0001;
    @(negedge CK_REF);
    n_checks++;
    if ({bus.P_RVALID, bus.D_RVALID, bus.P_RDATA} !== {2'b10, 32'h0000_0001}) begin
      n_fail++;
      $display("FAIL p_read_return: got rv=%b%b data=%h expected rv=10 data=00000001",
               bus.P_RVALID, bus.D_RVALID, bus.P_RDATA);
    end
    next_cycle();
    bus.MEM_ACCESS_DATA_IN_BUS = '0;
    @(negedge CK_REF);
    n_checks++;
    if ({bus.P_RVALID, bus.D_RVALID} !== 2'b00) begin
      n_fail++;
      $display("FAIL p_read_single_rvalid: got %b%b expected 00", bus.P_RVALID, bus.D_RVALID);
    end
  endtask

  task automatic test_p_write();
    apply_reset();
    set_p(1'b1, 1'b0, 16'h0004, 32'hDEAD_BEEF);
    @(negedge CK_REF);
    n_checks++;
    if ({bus.P_GNT, bus.D_GNT} !== 2'b10) begin
      n_fail++;
      $display("FAIL p_write_gnt: got %b%b expected 10", bus.P_GNT, bus.D_GNT);
    end
    next_cycle();
    set_p(1'b0, 1'b1, '0, '0);
    @(negedge CK_REF);
    n_checks++;
    if ({bus.MEM_ACCESS_READ_WRN, bus.MEM_ACCESS_ADDRESS_BUS, bus.MEM_ACCESS_DATA_OUT_BUS}
        !== {1'b0, 16'h0004, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL p_write_issue: got rw=%b addr=%h dout=%h expected rw=0 addr=0004 dout=deadbeef",
               bus.MEM_ACCESS_READ_WRN, bus.MEM_ACCESS_ADDRESS_BUS, bus.MEM_ACCESS_DATA_OUT_BUS);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({bus.P_RVALID, bus.D_RVALID} !== 2'b00) begin
        n_fail++;
        $display("FAIL p_write_no_rvalid[%0d]: got %b%b expected 00", k, bus.P_RVALID, bus.D_RVALID);
      end
      next_cycle();
      @(negedge CK_REF);
    end
  endtask

  task automatic test_starvation();
    logic [2:0] exp_g;
    apply_reset();
    set_p(1'b1, 1'b0, 16'h0100, 32'h1111_1111);
    set_d(1'b1, 1'b0, 16'h0200, 32'h2222_2222);
    for (int i = 0; i < 7; i++) begin
      @(negedge CK_REF);
      exp_g = (i == STARVE_LIMIT) ? 3'b011 : 3'b100;
      n_checks++;
      if ({bus.P_GNT, bus.D_GNT, bus.P_STALL} !== exp_g) begin
        n_fail++;
        $display("FAIL starve_gnt[%0d]: got %b expected %b", i,
                 {bus.P_GNT, bus.D_GNT, bus.P_STALL}, exp_g);
      end
      if (i == STARVE_LIMIT + 1) begin
        n_checks++;
        if ({bus.MEM_ACCESS_ADDRESS_BUS, bus.MEM_ACCESS_DATA_OUT_BUS} !== {16'h0200, 32'h2222_2222}) begin
          n_fail++;
          $display("FAIL starve_d_issue: got addr=%h dout=%h expected addr=0200 dout=22222222",
                   bus.MEM_ACCESS_ADDRESS_BUS, bus.MEM_ACCESS_DATA_OUT_BUS);
        end
      end
      next_cycle();
      if (i == STARVE_LIMIT) set_d(1'b0, 1'b1, '0, '0);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      set_p(k < 3, 1'b1, ADDR_W'(k + 1), '0);
      bus.MEM_ACCESS_DATA_IN_BUS = (k >= 2 && k <= 4) ? DATA_W'(k - 1) : 32'hFFFF_FFFF;
      @(negedge CK_REF);
      if (k < 3) begin
        n_checks++;
        if (bus.P_GNT !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_gnt[%0d]: got %b expected 1", k, bus.P_GNT);
        end
      end
      if (k >= 1 && k <= 3) begin
        n_checks++;
        if (bus.MEM_ACCESS_ADDRESS_BUS !== ADDR_W'(k)) begin
          n_fail++;
          $display("FAIL b2b_addr[%0d]: got %h expected %h", k, bus.MEM_ACCESS_ADDRESS_BUS, ADDR_W'(k));
        end
      end
      n_checks++;
      if (bus.P_RVALID !== (k >= 2 && k <= 4)) begin
        n_fail++;
        $display("FAIL b2b_rvalid[%0d]: got %b expected %b", k, bus.P_RVALID, (k >= 2 && k <= 4));
      end
      if (k >= 2 && k <= 4) begin
        n_checks++;
        if (bus.P_RDATA !== DATA_W'(k - 1)) begin
          n_fail++;
          $display("FAIL b2b_rdata[%0d]: got %h expected %h", k, bus.P_RDATA, DATA_W'(k - 1));
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_interleave();
    logic [1:0] exp_rv [5] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
    logic [DATA_W-1:0] din [5] = '{32'h0, 32'h0, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      set_p(k == 0, 1'b1, 16'h0020, '0);
      set_d(k == 1, 1'b1, 16'h0030, '0);
      bus.MEM_ACCESS_DATA_IN_BUS = din[k];
      @(negedge CK_REF);
      n_checks++;
      if ({bus.P_RVALID, bus.D_RVALID} !== exp_rv[k]) begin
        n_fail++;
        $display("FAIL interleave_rvalid[%0d]: got %b%b expected %b", k,
                 bus.P_RVALID, bus.D_RVALID, exp_rv[k]);
      end
      if (k == 1) begin
        n_checks++;
        if ({bus.P_GNT, bus.D_GNT, bus.MEM_ACCESS_ADDRESS_BUS} !== {2'b01, 16'h0020}) begin
          n_fail++;
          $display("FAIL interleave_d_gnt: got gnt=%b%b addr=%h expected gnt=01 addr=0020",
                   bus.P_GNT, bus.D_GNT, bus.MEM_ACCESS_ADDRESS_BUS);
        end
      end
      if (k == 3) begin
        n_checks++;
        if (bus.D_RDATA !== 32'hBBBB_0002) begin
          n_fail++;
          $display("FAIL interleave_d_rdata: got %h expected bbbb0002", bus.D_RDATA);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_p(1'b1, 1'b0, 16'h0004, 32'h1234_5678);
    next_cycle();
    set_p(1'b1, 1'b1, 16'h0040, '0);
    next_cycle();
    set_p(1'b1, 1'b1, 16'h0044, '0);
    @(negedge CK_REF);
    n_checks++;
    if ({bus.MEM_ACCESS_READ_WRN, bus.MEM_ACCESS_ADDRESS_BUS, bus.MEM_ACCESS_DATA_OUT_BUS}
        !== {1'b1, 16'h0040, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL mid_read_holds_dout: got rw=%b addr=%h dout=%h expected rw=1 addr=0040 dout=12345678",
               bus.MEM_ACCESS_READ_WRN, bus.MEM_ACCESS_ADDRESS_BUS, bus.MEM_ACCESS_DATA_OUT_BUS);
    end
    #2;
    RST_N = 1'b0;
    #1;
    n_checks++;
    if ({bus.P_GNT, bus.D_GNT, bus.P_RVALID, bus.D_RVALID, bus.MEM_ACCESS_READ_WRN,
         bus.MEM_ACCESS_ADDRESS_BUS, bus.MEM_ACCESS_DATA_OUT_BUS}
        !== {5'b00001, 16'h0000, 32'h0000_0000}) begin
      n_fail++;
      $display("FAIL mid_reset_async: got gnt=%b%b rv=%b%b rw=%b addr=%h dout=%h expected all reset values",
               bus.P_GNT, bus.D_GNT, bus.P_RVALID, bus.D_RVALID, bus.MEM_ACCESS_READ_WRN,
               bus.MEM_ACCESS_ADDRESS_BUS, bus.MEM_ACCESS_DATA_OUT_BUS);
    end
    idle_inputs();
    repeat (2) @(posedge CK_REF);
    #1;
    RST_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CK_REF);
      n_checks++;
      if ({bus.P_RVALID, bus.D_RVALID} !== 2'b00) begin
        n_fail++;
        $display("FAIL mid_reset_no_rvalid[%0d]: got %b%b expected 00", k, bus.P_RVALID, bus.D_RVALID);
      end
      next_cycle();
    end
  endtask

  typedef struct {
    int due;
    bit port;
  } rd_t;

  task automatic test_random();
    rd_t               q[$];
    bit                p_req = 0, d_req = 0, p_pend = 0, d_pend = 0;
    bit                p_rw, d_rw, ep, ed, forced, rv_p, rv_d;
    logic [ADDR_W-1:0] p_a, d_a, exp_addr = '0;
    logic [DATA_W-1:0] p_w, d_w, din, exp_dout = '0;
    bit                exp_rw = 1'b1;
    int                d_denied = 0;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      if (!p_pend) p_req = ($urandom_range(0, 3) != 0);
      if (!d_pend) d_req = ($urandom_range(0, 1) != 0);
      p_rw = 1'($urandom_range(0, 1)); p_a = ADDR_W'($urandom); p_w = DATA_W'($urandom);
      d_rw = 1'($urandom_range(0, 1)); d_a = ADDR_W'($urandom); d_w = DATA_W'($urandom);
      din  = DATA_W'($urandom);
      set_p(p_req, p_rw, p_a, p_w);
      set_d(d_req, d_rw, d_a, d_w);
      bus.MEM_ACCESS_DATA_IN_BUS = din;
      @(negedge CK_REF);

      // D wins once it has been refused STARVE_LIMIT cycles in a row.
      forced = d_req && (d_denied >= STARVE_LIMIT);
      ep     = p_req && !forced;
      ed     = d_req && !ep;
      rv_p   = (q.size() > 0) && (q[0].due == k) && !q[0].port;
      rv_d   = (q.size() > 0) && (q[0].due == k) && q[0].port;

      n_checks++;
      if ({bus.P_GNT, bus.D_GNT, bus.P_STALL} !== {ep, ed, p_req && !ep}) begin
        n_fail++;
        $display("FAIL rand_gnt[%0d]: got %b expected %b", k,
                 {bus.P_GNT, bus.D_GNT, bus.P_STALL}, {ep, ed, p_req && !ep});
      end
      n_checks++;
      if ({bus.MEM_ACCESS_READ_WRN, bus.MEM_ACCESS_ADDRESS_BUS, bus.MEM_ACCESS_DATA_OUT_BUS}
          !== {exp_rw, exp_addr, exp_dout}) begin
        n_fail++;
        $display("FAIL rand_bus[%0d]: got rw=%b addr=%h dout=%h expected rw=%b addr=%h dout=%h", k,
                 bus.MEM_ACCESS_READ_WRN, bus.MEM_ACCESS_ADDRESS_BUS, bus.MEM_ACCESS_DATA_OUT_BUS,
                 exp_rw, exp_addr, exp_dout);
      end
      n_checks++;
      if ({bus.P_RVALID, bus.D_RVALID} !== {rv_p, rv_d}) begin
        n_fail++;
        $display("FAIL rand_rvalid[%0d]: got %b%b expected %b%b", k,
                 bus.P_RVALID, bus.D_RVALID, rv_p, rv_d);
      end
      if (rv_p || rv_d) begin
        n_checks++;
        if ((rv_p ? bus.P_RDATA : bus.D_RDATA) !== din) begin
          n_fail++;
          $display("FAIL rand_rdata[%0d]: got %h expected %h", k,
                   rv_p ? bus.P_RDATA : bus.D_RDATA, din);
        end
        void'(q.pop_front());
      end

      d_denied = (d_req && !ed) ? d_denied + 1 : 0;
      if (ep) begin
        exp_rw = p_rw; exp_addr = p_a;
        if (!p_rw) exp_dout = p_w;
        else q.push_back('{k + 2, 1'b0});
      end else if (ed) begin
        exp_rw = d_rw; exp_addr = d_a;
        if (!d_rw) exp_dout = d_w;
        else q.push_back('{k + 2, 1'b1});
      end else begin
        exp_rw = 1'b1;
      end
      p_pend = p_req && !ep;
      d_pend = d_req && !ed;
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_p_read();
    test_p_write();
    test_starvation();
    test_back_to_back();
    test_interleave();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
